note_freq_glide: RTL and testbench

- Parametrised successor to the switch-to-frequency mapper.
- Synchronises and debounces the 6-bit note-select switches, then looks up a corrected 12-semitone table with octave shifting.
- Slews (portamento) the output frequency toward the new target at a programmable rate instead of jumping.
- Feeds the tone generator's frequency input; exposes settled/change status for LEDs and the control FSM.

---
 rtl/note_freq_glide.sv | 190 +++++++++++++++++++
 tb/tb_note_freq_glide.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/note_freq_glide.sv
// note_freq_glide: debounced 6-bit note switch to frequency, with portamento glide.
//   clk, rst_n   : system clock, asynchronous active-low reset (synchronous release)
//   sw[5:0]      : [5:4] octave code, [3] sharp, [2:0] note C..B (7 = invalid)
//   freq         : current (gliding) output frequency in Hz
//   target       : frequency of the accepted switch code in Hz
//   settled      : high when freq == target
//   note_change  : one-cycle pulse when a new switch code is accepted
module note_freq_glide #(
  parameter int unsigned FREQ_W       = 12,
  parameter int unsigned DEBOUNCE     = 16,
  parameter int unsigned GLIDE_DIV    = 1000,
  parameter int unsigned GLIDE_STEP   = 4,
  parameter int unsigned DEFAULT_FREQ = 440
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        sw,
  output logic [FREQ_W-1:0] freq,
  output logic [FREQ_W-1:0] target,
  output logic              settled,
  output logic              note_change
);

  localparam int unsigned DB_W  = (DEBOUNCE  > 1) ? $clog2(DEBOUNCE)  : 1;
  localparam int unsigned DIV_W = (GLIDE_DIV > 1) ? $clog2(GLIDE_DIV) : 1;
  localparam logic [5:0]        RESET_CODE = 6'b000101;
  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(GLIDE_DIV - 1);
  localparam logic [FREQ_W-1:0] DEF_F      = FREQ_W'(DEFAULT_FREQ);
  localparam logic [FREQ_W-1:0] STEP_F     = FREQ_W'(GLIDE_STEP);

  typedef enum logic {IDLE, GLIDE} state_e;

  state_e            state_q, state_d;
  logic [5:0]        sync1_q, sync1_d;
  logic [5:0]        sync2_q, sync2_d;
  logic [5:0]        cand_q, cand_d;
  logic [5:0]        acc_q, acc_d;
  logic [DB_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [FREQ_W-1:0] target_q, target_d;
  logic              settled_q, settled_d;
  logic              note_change_q, note_change_d;
  logic [FREQ_W-1:0] diff_c;
  logic [FREQ_W-1:0] step_c;

  // Switch code to Hz: semitone table at octave 4, then octave shift.
  function automatic logic [FREQ_W-1:0] lookup(input logic [5:0] code);
    logic [3:0]  semi;
    logic [8:0]  base;
    logic [10:0] scaled;
    semi   = 4'd0;
    base   = 9'd440;
    scaled = 11'd0;
    case (code[2:0])
      3'd0:    semi = 4'd0;
      3'd1:    semi = 4'd2;
      3'd2:    semi = 4'd4;
      3'd3:    semi = 4'd5;
      3'd4:    semi = 4'd7;
      3'd5:    semi = 4'd9;
      3'd6:    semi = 4'd11;
      default: semi = 4'd0;
    endcase
    // E and B have no sharp; the sharp bit is ignored for them
    if (code[3] && (code[2:0] != 3'd2) && (code[2:0] != 3'd6))
      semi = 4'(semi + 4'd1);
    case (semi)
      4'd0:    base = 9'd261;
      4'd1:    base = 9'd277;
      4'd2:    base = 9'd293;
      4'd3:    base = 9'd311;
      4'd4:    base = 9'd330;
      4'd5:    base = 9'd349;
      4'd6:    base = 9'd370;
      4'd7:    base = 9'd392;
      4'd8:    base = 9'd415;
      4'd9:    base = 9'd440;
      4'd10:   base = 9'd466;
      4'd11:   base = 9'd494;
      default: base = 9'd440;
    endcase
    case (code[5:4])
      2'd0:    scaled = {2'b00, base};
      2'd1:    scaled = {1'b0, base, 1'b0};
      2'd2:    scaled = {base, 2'b00};
      default: scaled = {3'b000, base[8:1]};
    endcase
    if (code[2:0] == 3'd7) return DEF_F;
    return FREQ_W'(scaled);
  endfunction

  // Synchroniser, candidate tracking and debounce acceptance.
  always_comb begin
    sync1_d       = sw;
    sync2_d       = sync1_q;
    cand_d        = cand_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    note_change_d = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cand_q != acc_q) begin
      if (cnt_q == DB_LAST) begin
        acc_d         = cand_q;
        cnt_d         = '0;
        note_change_d = 1'b1;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end
    target_d = lookup(acc_d);
  end

  // Distance to target and the clipped step so a tick never overshoots.
  always_comb begin
    diff_c = (target_q > freq_q) ? (target_q - freq_q) : (freq_q - target_q);
    step_c = (32'(diff_c) > GLIDE_STEP) ? STEP_F : diff_c;
  end

  // Glide FSM: next state, divider and frequency.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    freq_d  = freq_q;
    if (GLIDE_STEP == 0) begin
      state_d = IDLE;
      freq_d  = target_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (freq_q != target_q) begin
            state_d = GLIDE;
            div_d   = '0;
          end
        end
        GLIDE: begin
          if (freq_q == target_q) begin
            state_d = IDLE;
          end else if (div_q == DIV_LAST) begin
            div_d  = '0;
            freq_d = (target_q > freq_q) ? (freq_q + step_c) : (freq_q - step_c);
            if (freq_d == target_q) state_d = IDLE;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    settled_d = (freq_d == target_d);
  end

  // Synchroniser preloads the reset code so releasing reset is not seen as a switch change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sync1_q       <= RESET_CODE;
      sync2_q       <= RESET_CODE;
      cand_q        <= RESET_CODE;
      acc_q         <= RESET_CODE;
      cnt_q         <= '0;
      div_q         <= '0;
      freq_q        <= DEF_F;
      target_q      <= DEF_F;
      settled_q     <= 1'b1;
      note_change_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      cand_q        <= cand_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      div_q         <= div_d;
      freq_q        <= freq_d;
      target_q      <= target_d;
      settled_q     <= settled_d;
      note_change_q <= note_change_d;
    end
  end

  assign freq        = freq_q;
  assign target      = target_q;
  assign settled     = settled_q;
  assign note_change = note_change_q;

endmodule

// File: tb/tb_note_freq_glide.sv
// tb_note_freq_glide: directed bench with a jumping instance (GLIDE_STEP=0) and a
// gliding instance (GLIDE_DIV=2, GLIDE_STEP=4), both with DEBOUNCE=4.
module tb_note_freq_glide;

  logic        clk;
  logic        rst_n;
  logic [5:0]  sw_j, sw_g;
  logic [11:0] freq_j, target_j, freq_g, target_g;
  logic        settled_j, note_change_j, settled_g, note_change_g;

  int n_cmp = 0;
  int n_err = 0;
  int nc_cnt_j = 0;
  int nc_cnt_g = 0;

  note_freq_glide #(
    .FREQ_W(12), .DEBOUNCE(4), .GLIDE_DIV(2), .GLIDE_STEP(0), .DEFAULT_FREQ(440)
  ) u_jump (
    .clk(clk), .rst_n(rst_n), .sw(sw_j), .freq(freq_j), .target(target_j),
    .settled(settled_j), .note_change(note_change_j)
  );

  note_freq_glide #(
    .FREQ_W(12), .DEBOUNCE(4), .GLIDE_DIV(2), .GLIDE_STEP(4), .DEFAULT_FREQ(440)
  ) u_glide (
    .clk(clk), .rst_n(rst_n), .sw(sw_g), .freq(freq_g), .target(target_g),
    .settled(settled_g), .note_change(note_change_g)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (note_change_j) nc_cnt_j++;
    if (note_change_g) nc_cnt_g++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply a code to the jumping instance and check the looked-up frequency.
  task automatic apply_j(input logic [5:0] code, input int exp, input string tag);
    @(negedge clk);
    sw_j = code;
    repeat (9) @(negedge clk);
    check(tag, 32'(target_j), 32'(exp));
    check({tag, "_freq"}, 32'(freq_j), 32'(exp));
  endtask

  initial begin
    int cyc, last, gap_exp, expf, prev, bad, over, start;
    rst_n = 1'b0;
    sw_j  = 6'b000101;
    sw_g  = 6'b000101;
    repeat (3) @(negedge clk);
    check("rst_freq",    32'(freq_g),        32'd440);
    check("rst_target",  32'(target_g),      32'd440);
    check("rst_settled", 32'(settled_g),     32'd1);
    check("rst_nc",      32'(note_change_g), 32'd0);
    rst_n = 1'b1;

    // Hold the reset code: nothing may change
    repeat (20) @(negedge clk);
    check("hold_freq",    32'(freq_j),    32'd440);
    check("hold_target",  32'(target_j),  32'd440);
    check("hold_settled", 32'(settled_j), 32'd1);
    check("hold_nc_j",    32'(nc_cnt_j),  32'd0);
    check("hold_nc_g",    32'(nc_cnt_g),  32'd0);

    // Glitch of 3 cycles is shorter than DEBOUNCE
    @(negedge clk);
    sw_j = 6'b000000;
    repeat (3) @(negedge clk);
    sw_j = 6'b000101;
    repeat (12) @(negedge clk);
    check("glitch_target", 32'(target_j), 32'd440);
    check("glitch_nc",     32'(nc_cnt_j), 32'd0);

    // Jump to B5 = 988: target 6 cycles after the first sampling edge
    @(negedge clk);
    sw_j = 6'b010110;
    repeat (6) @(negedge clk);
    check("lat_target_early", 32'(target_j),      32'd440);
    check("lat_nc_early",     32'(note_change_j), 32'd0);
    @(negedge clk);
    check("lat_target",       32'(target_j),      32'd988);
    check("lat_nc_pulse",     32'(note_change_j), 32'd1);
    check("lat_freq_old",     32'(freq_j),        32'd440);
    check("lat_unsettled",    32'(settled_j),     32'd0);
    @(negedge clk);
    check("jump_freq",        32'(freq_j),        32'd988);
    check("jump_nc_low",      32'(note_change_j), 32'd0);
    check("jump_settled",     32'(settled_j),     32'd1);
    check("jump_nc_count",    32'(nc_cnt_j),      32'd1);

    // Lookup boundaries
    apply_j(6'b001010, 330, "e_sharp");
    apply_j(6'b111111, 440, "code7");
    apply_j(6'b110000, 130, "c3");
    apply_j(6'b011001, 622, "ds5");
    check("boundary_nc_count", 32'(nc_cnt_j), 32'd5);

    // Glide 440 -> 261, 4 Hz every 2 cycles, last step 3
    @(negedge clk);
    sw_g = 6'b000000;
    for (int i = 0; i < 20 && target_g != 12'd261; i++) @(negedge clk);
    check("glide_target", 32'(target_g), 32'd261);
    cyc = 0; last = 0; gap_exp = 3; expf = 440; prev = 440;
    for (int i = 0; i < 200 && freq_g != 12'd261; i++) begin
      @(negedge clk);
      cyc++;
      if (32'(freq_g) != prev) begin
        expf = (expf - 261 > 4) ? expf - 4 : 261;
        check("glide_val", 32'(freq_g), 32'(expf));
        check("glide_gap", 32'(cyc - last), 32'(gap_exp));
        if (freq_g != 12'd261) check("glide_unsettled", 32'(settled_g), 32'd0);
        gap_exp = 2; last = cyc; prev = 32'(freq_g);
      end
    end
    check("glide_end",     32'(freq_g),    32'd261);
    check("glide_settled", 32'(settled_g), 32'd1);
    repeat (6) @(negedge clk);
    check("glide_stays",   32'(freq_g),    32'd261);

    // Back to 440, then retarget mid-glide: E3 (165) then A6 (1760)
    sw_g = 6'b000101;
    for (int i = 0; i < 300 && !(freq_g == 12'd440 && settled_g); i++) @(negedge clk);
    check("return_440", 32'(freq_g), 32'd440);
    sw_g = 6'b000000;
    for (int i = 0; i < 300 && freq_g != 12'd400; i++) @(negedge clk);
    check("reach_400", 32'(freq_g), 32'd400);
    sw_g = 6'b111010;
    for (int i = 0; i < 20 && target_g != 12'd165; i++) @(negedge clk);
    check("e3_target", 32'(target_g), 32'd165);
    sw_g = 6'b100101;
    for (int i = 0; i < 20 && target_g != 12'd1760; i++) @(negedge clk);
    check("a6_target", 32'(target_g), 32'd1760);
    start = 32'(freq_g);
    check("reverse_point", 32'(start < 400 && start > 165), 32'd1);
    prev = start; bad = 0; over = 0;
    for (int i = 0; i < 2000 && freq_g != 12'd1760; i++) begin
      @(negedge clk);
      if (freq_g > 12'd1760) over++;
      if (32'(freq_g) != prev) begin
        if (32'(freq_g) != prev + 4) bad++;
        prev = 32'(freq_g);
      end
    end
    check("rise_step_bad",  32'(bad),       32'd0);
    check("rise_overshoot", 32'(over),      32'd0);
    check("rise_end",       32'(freq_g),    32'd1760);
    check("rise_settled",   32'(settled_g), 32'd1);

    // Asynchronous reset in the middle of a glide
    sw_g = 6'b000000;
    for (int i = 0; i < 20 && target_g != 12'd261; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("pre_reset_gliding", 32'(freq_g < 12'd1760 && freq_g > 12'd261), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_freq",    32'(freq_g),    32'd440);
    check("async_rst_target",  32'(target_g),  32'd440);
    check("async_rst_settled", 32'(settled_g), 32'd1);
    sw_g = 6'b000101;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nc_cnt_g = 0;
    repeat (20) @(negedge clk);
    check("post_rst_freq", 32'(freq_g),   32'd440);
    check("post_rst_nc",   32'(nc_cnt_g), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
